logic_unit_pipe: RTL and testbench

Registered, flow-controlled wrapper around the bitwise gate functions (inv/and/or/xor/nand/nor) plus all-ones reduction. It takes operand pairs and an opcode from an upstream producer with a valid/ready handshake and runs them through a two-stage pipeline. It delivers the result with zero/all-ones/error flags to a downstream consumer, and counts completed transactions. It is the sequential stage that sits directly downstream of the operand source and feeds result consumers.

---
 rtl/logic_unit_pipe.sv | 103 ++++++++++
 tb/tb_logic_unit_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline around the bitwise gate functions (inv/and/or/xor/nand/nor).
// The result registers also carry zero, all-ones and illegal-opcode flags, plus a count of completed transfers.
module logic_unit_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  input  logic [2:0]       in_op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_y_o,
  output logic             out_zero_o,
  output logic             out_ones_o,
  output logic             out_err_o,
  output logic [7:0]       out_count_o
);
  typedef enum logic [2:0] {
    OP_INV  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101
  } op_e;

  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             s1_vld_q;

  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, ones_q, err_q, err_d, s2_vld_q;
  logic [7:0]       cnt_q;

  logic s2_free, s1_adv, in_xfer, out_xfer;

  // out_ready feeds straight through to in_ready so a full pipe can refill the same cycle it drains
  assign s2_free    = !s2_vld_q || out_ready_i;
  assign s1_adv     = s1_vld_q && s2_free;
  assign in_ready_o = !s1_vld_q || s2_free;
  assign in_xfer    = in_valid_i && in_ready_o;
  assign out_xfer   = s2_vld_q && out_ready_i;

  always_comb begin
    y_d   = '0;
    err_d = 1'b0;
    case (op_q)
      OP_INV:  y_d = ~a_q;
      OP_AND:  y_d = a_q & b_q;
      OP_OR:   y_d = a_q | b_q;
      OP_XOR:  y_d = a_q ^ b_q;
      OP_NAND: y_d = ~(a_q & b_q);
      OP_NOR:  y_d = ~(a_q | b_q);
      default: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      s1_vld_q <= 1'b0;
      y_q      <= '0;
      zero_q   <= 1'b0;
      ones_q   <= 1'b0;
      err_q    <= 1'b0;
      s2_vld_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (in_xfer) begin
        a_q      <= in_a_i;
        b_q      <= in_b_i;
        op_q     <= in_op_i;
        s1_vld_q <= 1'b1;
      end else if (s1_adv) begin
        s1_vld_q <= 1'b0;
      end
      // S2 only loads on advance, so a stalled result never changes
      if (s1_adv) begin
        y_q      <= y_d;
        zero_q   <= (y_d == '0);
        ones_q   <= &y_d;
        err_q    <= err_d;
        s2_vld_q <= 1'b1;
      end else if (out_ready_i) begin
        s2_vld_q <= 1'b0;
      end
      if (out_xfer) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign out_valid_o = s2_vld_q;
  assign out_y_o     = y_q;
  assign out_zero_o  = zero_q;
  assign out_ones_o  = ones_q;
  assign out_err_o   = err_q;
  assign out_count_o = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomized self-checking bench for logic_unit_pipe (WIDTH=4).
module tb_logic_unit_pipe;
  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [3:0] in_a_i, in_b_i;
  logic [2:0] in_op_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [3:0] out_y_o;
  logic       out_zero_o, out_ones_o, out_err_o;
  logic [7:0] out_count_o;

  int checks   = 0;
  int failures = 0;

  logic [4:0] sb[$];
  logic [3:0] sweep_y[7] = '{4'b0011, 4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b0000};

  logic_unit_pipe #(.WIDTH(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_a_i(in_a_i), .in_b_i(in_b_i), .in_op_i(in_op_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_y_o(out_y_o), .out_zero_o(out_zero_o), .out_ones_o(out_ones_o),
    .out_err_o(out_err_o), .out_count_o(out_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result: {err, y}
  function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return {1'b0, ~a};
      3'd1:    return {1'b0, a & b};
      3'd2:    return {1'b0, a | b};
      3'd3:    return {1'b0, a ^ b};
      3'd4:    return {1'b0, ~(a & b)};
      3'd5:    return {1'b0, ~(a | b)};
      default: return {1'b1, 4'b0000};
    endcase
  endfunction

  task automatic run_one(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                         input logic [3:0] ey, input logic ez, input logic eo, input logic ee);
    @(negedge clk_i);
    in_a_i = a; in_b_i = b; in_op_i = op; in_valid_i = 1'b1; out_ready_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    chk({tag, "_lat1"}, out_valid_o, 0);
    @(negedge clk_i);
    chk({tag, "_valid"}, out_valid_o, 1);
    chk({tag, "_y"},     out_y_o, ey);
    chk({tag, "_zero"},  out_zero_o, ez);
    chk({tag, "_ones"},  out_ones_o, eo);
    chk({tag, "_err"},   out_err_o, ee);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_cnt;
    logic [4:0] e;
    int sent, recv, cyc;
    bit clr;

    reset_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_a_i = '0; in_b_i = '0; in_op_i = '0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_y",     out_y_o, 0);
    chk("rst_zero",  out_zero_o, 0);
    chk("rst_ones",  out_ones_o, 0);
    chk("rst_err",   out_err_o, 0);
    chk("rst_count", out_count_o, 0);
    chk("rst_ready", in_ready_o, 1);

    run_one("single_and", 4'b1100, 4'b1010, 3'b001, 4'b1000, 1'b0, 1'b0, 1'b0);
    chk("single_cnt_pre", out_count_o, 0);
    @(negedge clk_i);
    chk("single_cnt_post", out_count_o, 1);
    chk("single_drained", out_valid_o, 0);

    // back-to-back sweep, one result per cycle
    for (int t = 0; t < 9; t++) begin
      if (t > 0) @(negedge clk_i);
      if (t >= 2) begin
        chk("sweep_valid", out_valid_o, 1);
        chk("sweep_y",     out_y_o, sweep_y[t-2]);
        chk("sweep_err",   out_err_o, (t == 8) ? 1 : 0);
        chk("sweep_zero",  out_zero_o, (t == 8) ? 1 : 0);
      end
      if (t < 7) begin
        in_a_i = 4'b1100; in_b_i = 4'b1010; in_op_i = 3'(t); in_valid_i = 1'b1; out_ready_i = 1'b1;
      end else begin
        in_valid_i = 1'b0;
      end
    end
    @(negedge clk_i);
    chk("sweep_cnt", out_count_o, 8);
    chk("sweep_empty", out_valid_o, 0);

    run_one("flag_ones", 4'b1111, 4'b0000, 3'b010, 4'b1111, 1'b0, 1'b1, 1'b0);
    run_one("flag_zero", 4'b0101, 4'b0101, 3'b011, 4'b0000, 1'b1, 1'b0, 1'b0);
    run_one("illegal7",  4'b1111, 4'b1111, 3'b111, 4'b0000, 1'b1, 1'b0, 1'b1);
    @(negedge clk_i);
    chk("flag_cnt", out_count_o, 11);

    // backpressure: out_ready low, only two items fit
    out_ready_i = 1'b0;
    chk("bp_rdy0", in_ready_o, 1);
    in_a_i = 4'b0001; in_b_i = 4'b0000; in_op_i = 3'b010; in_valid_i = 1'b1;
    @(negedge clk_i);
    chk("bp_rdy1", in_ready_o, 1);
    in_a_i = 4'b0010;
    @(negedge clk_i);
    chk("bp_full_rdy", in_ready_o, 0);
    chk("bp_full_valid", out_valid_o, 1);
    chk("bp_full_y", out_y_o, 4'b0001);
    in_a_i = 4'b0100;
    @(negedge clk_i);
    chk("bp_stall_rdy", in_ready_o, 0);
    chk("bp_stall_y", out_y_o, 4'b0001);
    chk("bp_stall_cnt", out_count_o, 11);
    out_ready_i = 1'b1;
    #1;
    chk("bp_release_rdy", in_ready_o, 1);
    @(negedge clk_i);
    chk("bp_drain_y1", out_y_o, 4'b0010);
    in_a_i = 4'b1000;
    @(negedge clk_i);
    chk("bp_drain_y2", out_y_o, 4'b0100);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("bp_drain_y3", out_y_o, 4'b1000);
    @(negedge clk_i);
    chk("bp_empty", out_valid_o, 0);
    chk("bp_cnt", out_count_o, 15);

    // random valid/ready with scoreboard; count wraps past 255
    exp_cnt = 8'd15; sent = 0; recv = 0; cyc = 0; clr = 0;
    while (recv < 1000 && cyc < 20000) begin
      @(negedge clk_i);
      cyc++;
      if (clr) begin in_valid_i = 1'b0; clr = 0; end
      out_ready_i = ($urandom_range(0, 1) == 1);
      if (!in_valid_i && sent < 1000 && $urandom_range(0, 3) != 0) begin
        in_a_i = 4'($urandom); in_b_i = 4'($urandom); in_op_i = 3'($urandom_range(0, 7));
        in_valid_i = 1'b1;
      end
      #1;
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) chk("rand_spurious", out_valid_o, 0);
        else begin
          e = sb.pop_front();
          chk("rand_y",    out_y_o, e[3:0]);
          chk("rand_err",  out_err_o, e[4]);
          chk("rand_zero", out_zero_o, (e[3:0] == 4'b0000));
          chk("rand_ones", out_ones_o, (e[3:0] == 4'b1111));
          chk("rand_cnt",  out_count_o, exp_cnt);
          exp_cnt = exp_cnt + 8'd1;
          recv++;
        end
      end
      if (in_valid_i && in_ready_o) begin
        sb.push_back(model(in_a_i, in_b_i, in_op_i));
        sent++;
        clr = 1;
      end
    end
    in_valid_i = 1'b0;
    chk("rand_recv", recv, 1000);
    @(negedge clk_i);
    chk("rand_final_cnt", out_count_o, 247);
    chk("rand_empty", out_valid_o, 0);

    // reset with both stages full
    out_ready_i = 1'b0;
    in_a_i = 4'b0011; in_b_i = 4'b0000; in_op_i = 3'b010; in_valid_i = 1'b1;
    @(negedge clk_i);
    in_a_i = 4'b0110;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    chk("mid_full_rdy", in_ready_o, 0);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    chk("mid_rst_valid", out_valid_o, 0);
    chk("mid_rst_cnt", out_count_o, 0);
    chk("mid_rst_rdy", in_ready_o, 1);
    run_one("post_rst", 4'b1100, 4'b1010, 3'b011, 4'b0110, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("post_rst_cnt", out_count_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
